// File: rtl/uart_tx.sv
// UART transmitter: parallel byte in through a start/busy handshake, serial frame out
// (start bit, LSB-first data, optional parity, one or two stop bits) on a registered line.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic            PAR_ODD   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [2:0]             idx, idx_nxt;
    logic [DATA_BITS-1:0]   shreg, shreg_nxt;
    logic                   par, par_nxt;
    logic                   out_nxt, busy_nxt, done_nxt;
    logic                   bit_end;

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            shreg   <= shreg_nxt;
            par     <= par_nxt;
            tx_out  <= out_nxt;
            tx_busy <= busy_nxt;
            tx_done <= done_nxt;
        end
    end

    // Every output is computed one cycle ahead so the line comes straight off a flop.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        par_nxt   = par;
        out_nxt   = tx_out;
        busy_nxt  = tx_busy;
        done_nxt  = 1'b0;

        if (state != IDLE)
            cnt_nxt = bit_end ? '0 : cnt + 1'b1;

        case (state)
            IDLE: begin
                out_nxt  = 1'b1;
                busy_nxt = 1'b0;
                if (tx_start) begin
                    shreg_nxt = tx_data;
                    par_nxt   = (^tx_data) ^ PAR_ODD;
                    out_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    out_nxt   = shreg[0];
                    shreg_nxt = shreg >> 1;
                    idx_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == DATA_LAST) begin
                        idx_nxt = '0;
                        if (PARITY_EN != 0) begin
                            out_nxt   = par;
                            state_nxt = PARITY;
                        end else begin
                            out_nxt   = 1'b1;
                            state_nxt = STOP;
                        end
                    end else begin
                        out_nxt   = shreg[0];
                        shreg_nxt = shreg >> 1;
                        idx_nxt   = idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    out_nxt   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                out_nxt = 1'b1;
                if (bit_end) begin
                    if (idx == STOP_LAST) begin
                        idx_nxt   = '0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            default: begin
                out_nxt   = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: four configurations driven in parallel, each line
// watched by a monitor that compares every cycle against frames built from the frame rules.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int ND = 4;
    localparam int CPB  [ND] = '{4, 4, 3, 2};
    localparam int DB   [ND] = '{8, 8, 8, 5};
    localparam int PEN  [ND] = '{0, 1, 1, 0};
    localparam int PODD [ND] = '{0, 0, 1, 0};
    localparam int SB   [ND] = '{1, 1, 2, 2};

    typedef struct {
        logic [15:0] b;
        int          n;
    } frame_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst_edge = 1'b1;
    logic [ND-1:0]       tx_start = '0;
    logic [ND-1:0][7:0]  tx_data = '0;
    logic [ND-1:0]       tx_out, tx_busy, tx_done;

    frame_t exp_q[ND][$];
    int     starts[ND];
    int     n_chk = 0;
    int     n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rst_edge <= reset;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        uart_tx #(
            .CLKS_PER_BIT(CPB[g]), .DATA_BITS(DB[g]), .PARITY_EN(PEN[g]),
            .PARITY_ODD(PODD[g]), .STOP_BITS(SB[g])
        ) u_dut (
            .clk(clk), .reset(reset), .tx_start(tx_start[g]),
            .tx_data(tx_data[g][DB[g]-1:0]),
            .tx_out(tx_out[g]), .tx_busy(tx_busy[g]), .tx_done(tx_done[g])
        );
    end

    task automatic chk(input bit ok, input string name, input int d, input int got, input int want);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s dut=%0d got=%0h want=%0h t=%0t", name, d, got, want, $time);
        end
    endtask

    // Reference frame: list of line levels, one per bit period.
    function automatic frame_t model(input int d, input logic [7:0] data);
        frame_t f;
        logic [7:0] m;
        f.b = '1;
        f.n = 0;
        f.b[f.n] = 1'b0; f.n++;
        for (int i = 0; i < DB[d]; i++) begin
            f.b[f.n] = data[i]; f.n++;
        end
        if (PEN[d] != 0) begin
            m = 8'((1 << DB[d]) - 1);
            f.b[f.n] = 1'(($countones(data & m) + PODD[d]) % 2); f.n++;
        end
        f.n += SB[d];
        return f;
    endfunction

    task automatic mon(input int d);
        bit     in_f = 0, exp_done = 0, err = 0;
        logic   prev = 1'b1;
        int     cyc = 0, idx, got = 0;
        frame_t cur;
        forever begin
            @(negedge clk);
            if (rst_edge) begin
                chk(tx_out[d] === 1'b1 && tx_busy[d] === 1'b0 && tx_done[d] === 1'b0,
                    "reset_state", d, {tx_out[d], tx_busy[d], tx_done[d]}, 3'b100);
                in_f = 0;
                exp_done = 0;
            end else begin
                if (exp_done) begin
                    chk(tx_out[d] === 1'b1 && tx_busy[d] === 1'b0 && tx_done[d] === 1'b1,
                        "done_pulse", d, {tx_out[d], tx_busy[d], tx_done[d]}, 3'b101);
                    exp_done = 0;
                end else if (!in_f) begin
                    if (prev === 1'b1 && tx_out[d] === 1'b0) begin
                        starts[d]++;
                        chk(exp_q[d].size() > 0, "unexpected_start", d, 1, 0);
                        if (exp_q[d].size() > 0) begin
                            cur = exp_q[d].pop_front();
                            in_f = 1;
                            cyc = 0;
                            err = 0;
                        end
                    end else begin
                        chk(tx_out[d] === 1'b1 && tx_busy[d] === 1'b0 && tx_done[d] === 1'b0,
                            "idle_line", d, {tx_out[d], tx_busy[d], tx_done[d]}, 3'b100);
                    end
                end
                if (in_f) begin
                    idx = cyc / CPB[d];
                    if (tx_out[d] !== cur.b[idx] || tx_busy[d] !== 1'b1 || tx_done[d] !== 1'b0) begin
                        err = 1;
                        got = {tx_out[d], tx_busy[d], tx_done[d]};
                    end
                    if (cyc % CPB[d] == CPB[d] - 1) begin
                        chk(!err, $sformatf("frame_bit%0d", idx), d, got, {cur.b[idx], 2'b10});
                        err = 0;
                    end
                    cyc++;
                    if (cyc == cur.n * CPB[d]) begin
                        in_f = 0;
                        exp_done = 1;
                    end
                end
            end
            prev = tx_out[d];
        end
    endtask

    task automatic wait_idle(input int d);
        int t = 0;
        while (tx_busy[d] !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk(0, "idle_timeout", d, t, 1000);
    endtask

    // Called on a falling edge; returns on the falling edge after the accept edge.
    task automatic send(input int d, input logic [7:0] data);
        wait_idle(d);
        tx_start[d] = 1'b1;
        tx_data[d] = data;
        exp_q[d].push_back(model(d, data));
        @(negedge clk);
        tx_start[d] = 1'b0;
    endtask

    task automatic seq_basic(input int d);
        send(d, 8'hA5);
        send(d, 8'h07);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(d, 8'($urandom));
        end
        wait_idle(d);
    endtask

    task automatic seq_midframe(input int d);
        send(d, 8'h00);
        tx_data[d] = 8'hFF;
        repeat (2 * CPB[d]) @(negedge clk);
        tx_start[d] = 1'b1;
        @(negedge clk);
        tx_start[d] = 1'b0;
        wait_idle(d);
        repeat (3 * CPB[d]) @(negedge clk);
    endtask

    task automatic seq_b2b(input int d);
        int s0, t;
        s0 = starts[d];
        send(d, 8'hA5);
        t = 0;
        while (tx_done[d] !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk(t < 1000, "done_wait", d, t, 1000);
        tx_start[d] = 1'b1;
        tx_data[d] = 8'h3C;
        exp_q[d].push_back(model(d, 8'h3C));
        @(negedge clk);
        tx_start[d] = 1'b0;
        chk(tx_out[d] === 1'b0 && tx_busy[d] === 1'b1, "b2b_start", d,
            {tx_out[d], tx_busy[d]}, 2'b01);
        wait_idle(d);
        repeat (CPB[d] + 2) @(negedge clk);
        chk(starts[d] - s0 == 2, "start_events", d, starts[d] - s0, 2);
    endtask

    task automatic seq_reset(input int d);
        send(d, 8'hF0);
        repeat (4 * CPB[d] + 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        // reset and request together: request must be dropped
        reset = 1'b1;
        tx_start[d] = 1'b1;
        tx_data[d] = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        tx_start[d] = 1'b0;
        repeat (2 * CPB[d]) @(negedge clk);
        send(d, 8'h55);
        wait_idle(d);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        fork
            mon(0); mon(1); mon(2); mon(3);
        join_none
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < ND; i++) starts[i] = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        fork
            seq_basic(0); seq_basic(1); seq_basic(2); seq_basic(3);
        join
        repeat (4) @(negedge clk);
        fork
            seq_midframe(0); seq_midframe(1); seq_midframe(2); seq_midframe(3);
        join
        fork
            seq_b2b(0); seq_b2b(1); seq_b2b(2); seq_b2b(3);
        join
        for (int d = 0; d < ND; d++) seq_reset(d);
        repeat (10) @(negedge clk);
        for (int d = 0; d < ND; d++)
            chk(exp_q[d].size() == 0, "leftover_frames", d, exp_q[d].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
